// File: rtl/pixel_packer_if.sv
// Pixel-in / word-out bus of the pixel packer, plus its status outputs.
// Both streams use valid/ready: a beat transfers on a rising edge where valid && ready are both high.
// A producer holds its data stable while valid is high and not yet accepted.
interface pixel_packer_if;
   logic        i_start;
   logic [31:0] i_img_length;
   logic        i_pix_valid;
   logic [7:0]  i_pix_data;
   logic        o_pix_ready;
   logic        o_word_valid;
   logic [31:0] o_word_data;
   logic        i_word_ready;
   logic [31:0] o_img_data_length;
   logic [31:0] o_img_data_counter;
   logic        o_busy;
   logic        o_done;
   logic [1:0]  o_state_dbg;

   modport master (
      output i_start, i_img_length, i_pix_valid, i_pix_data, i_word_ready,
      input  o_pix_ready, o_word_valid, o_word_data, o_img_data_length,
             o_img_data_counter, o_busy, o_done, o_state_dbg
   );

   modport slave (
      input  i_start, i_img_length, i_pix_valid, i_pix_data, i_word_ready,
      output o_pix_ready, o_word_valid, o_word_data, o_img_data_length,
             o_img_data_counter, o_busy, o_done, o_state_dbg
   );
endinterface

// File: rtl/pixel_packer.sv
// Packs a stream of byte pixels into 32-bit little-endian words (first pixel in [7:0]).
// A partial final word is zero-padded; the committed pixel counter advances on word acceptance.
module pixel_packer (
   input logic           clk,
   input logic           rst_n,
   pixel_packer_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_OUT  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  lane_q, lane_d;
   logic [31:0] acc_q, acc_d;
   logic [31:0] word_q, word_d;
   logic [31:0] len_q, len_d;
   logic [31:0] cnt_q, cnt_d;

   logic        start_ok;
   logic        pix_fire;
   logic        word_fire;
   logic [31:0] acc_inc;
   logic        fill_last;

   assign start_ok  = bus.i_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign pix_fire  = bus.i_pix_valid && (state_q == ST_FILL);
   assign word_fire = bus.i_word_ready && (state_q == ST_OUT);
   assign acc_inc   = acc_q + 32'd1;
   // The word closes on its fourth lane or on the image's last pixel.
   assign fill_last = (lane_q == 2'd3) || (acc_inc == len_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.i_start) begin
               state_d = (bus.i_img_length == 32'd0) ? ST_DONE : ST_FILL;
            end
         end
         ST_FILL: begin
            if (pix_fire && fill_last) begin
               state_d = ST_OUT;
            end
         end
         ST_OUT: begin
            // After acceptance the committed count equals acc_q.
            if (bus.i_word_ready) begin
               state_d = (acc_q >= len_q) ? ST_DONE : ST_FILL;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.o_pix_ready  = (state_q == ST_FILL);
      bus.o_word_valid = (state_q == ST_OUT);
      bus.o_busy       = (state_q == ST_FILL) || (state_q == ST_OUT);
      bus.o_done       = (state_q == ST_DONE);
      bus.o_state_dbg  = state_q;
   end

   always_comb begin
      lane_d = lane_q;
      acc_d  = acc_q;
      word_d = word_q;
      len_d  = len_q;
      cnt_d  = cnt_q;
      if (start_ok) begin
         len_d  = bus.i_img_length;
         cnt_d  = 32'd0;
         lane_d = 2'd0;
         acc_d  = 32'd0;
         word_d = 32'd0;
      end else if (pix_fire) begin
         word_d[{lane_q, 3'b000} +: 8] = bus.i_pix_data;
         lane_d = (lane_q == 2'd3) ? 2'd3 : lane_q + 2'd1;
         acc_d  = acc_inc;
      end else if (word_fire) begin
         cnt_d  = acc_q;
         word_d = 32'd0;
         lane_d = 2'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_q <= 2'd0;
         acc_q  <= 32'd0;
         word_q <= 32'd0;
         len_q  <= 32'd0;
         cnt_q  <= 32'd0;
      end else begin
         lane_q <= lane_d;
         acc_q  <= acc_d;
         word_q <= word_d;
         len_q  <= len_d;
         cnt_q  <= cnt_d;
      end
   end

   assign bus.o_word_data        = word_q;
   assign bus.o_img_data_length  = len_q;
   assign bus.o_img_data_counter = cnt_q;

endmodule

// File: tb/tb_pixel_packer.sv
// Directed bench for pixel_packer: full and partial images, backpressure, empty image,
// mid-image reset and i_start pulses while busy.
module tb_pixel_packer;

   logic clk;
   logic rst_n;
   pixel_packer_if bus ();

   pixel_packer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks;
   int failures;
   logic [31:0] got_w_q[$];
   logic [31:0] got_c_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] exp_c_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_start(input logic [31:0] len);
      @(negedge clk);
      bus.i_start      = 1'b1;
      bus.i_img_length = len;
      @(negedge clk);
      bus.i_start      = 1'b0;
   endtask

   // Entered on a negedge; feeds n pixels with full word readiness until o_done.
   task automatic stream_pixels(input int n, input logic [7:0] first,
                                output int cycles, output bit done_seen);
      int idx;
      idx = 0;
      done_seen = 1'b0;
      cycles = 0;
      got_w_q.delete();
      got_c_q.delete();
      for (int c = 0; c < 300; c++) begin
         if (bus.o_done) begin
            done_seen = 1'b1;
            cycles = c;
            break;
         end
         if (bus.o_word_valid) begin
            got_w_q.push_back(bus.o_word_data);
            got_c_q.push_back(bus.o_img_data_counter);
         end
         bus.i_word_ready = 1'b1;
         if (bus.o_pix_ready && idx < n) begin
            bus.i_pix_valid = 1'b1;
            bus.i_pix_data  = first + 8'(idx);
            idx++;
         end else begin
            bus.i_pix_valid = 1'b0;
         end
         @(negedge clk);
      end
      bus.i_pix_valid = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.o_pix_ready, bus.o_word_valid, bus.o_busy, bus.o_done} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=0000",
                  {bus.o_pix_ready, bus.o_word_valid, bus.o_busy, bus.o_done});
      end
      checks++;
      if (bus.o_word_data !== 32'd0) begin
         failures++; $display("FAIL reset_word got=%h exp=0", bus.o_word_data);
      end
      checks++;
      if (bus.o_img_data_length !== 32'd0) begin
         failures++; $display("FAIL reset_len got=%0d exp=0", bus.o_img_data_length);
      end
      checks++;
      if (bus.o_img_data_counter !== 32'd0) begin
         failures++; $display("FAIL reset_cnt got=%0d exp=0", bus.o_img_data_counter);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_len8;
      int cyc;
      bit dn;
      exp_q = '{32'h04030201, 32'h08070605};
      exp_c_q = '{32'd0, 32'd4};
      do_start(32'd8);
      stream_pixels(8, 8'h01, cyc, dn);
      checks++;
      if (!dn || cyc != 10) begin
         failures++; $display("FAIL len8_latency done=%0d cycles=%0d exp=10", dn, cyc);
      end
      checks++;
      if (got_w_q.size() != 2) begin
         failures++; $display("FAIL len8_nwords got=%0d exp=2", got_w_q.size());
      end
      for (int i = 0; i < got_w_q.size() && i < 2; i++) begin
         checks++;
         if (got_w_q[i] !== exp_q[i]) begin
            failures++; $display("FAIL len8_word%0d got=%h exp=%h", i, got_w_q[i], exp_q[i]);
         end
         checks++;
         if (got_c_q[i] !== exp_c_q[i]) begin
            failures++; $display("FAIL len8_cnt%0d got=%0d exp=%0d", i, got_c_q[i], exp_c_q[i]);
         end
      end
      checks++;
      if (bus.o_img_data_counter !== 32'd8 || bus.o_done !== 1'b1 || bus.o_busy !== 1'b0) begin
         failures++;
         $display("FAIL len8_end cnt=%0d done=%b busy=%b exp=8/1/0",
                  bus.o_img_data_counter, bus.o_done, bus.o_busy);
      end
   endtask

   task automatic test_partial;
      int cyc;
      bit dn;
      exp_q = '{32'hA4A3A2A1, 32'h0000A6A5};
      exp_c_q = '{32'd0, 32'd4};
      do_start(32'd6);
      stream_pixels(6, 8'hA1, cyc, dn);
      checks++;
      if (!dn || cyc != 8) begin
         failures++; $display("FAIL len6_latency done=%0d cycles=%0d exp=8", dn, cyc);
      end
      checks++;
      if (got_w_q.size() != 2) begin
         failures++; $display("FAIL len6_nwords got=%0d exp=2", got_w_q.size());
      end
      for (int i = 0; i < got_w_q.size() && i < 2; i++) begin
         checks++;
         if (got_w_q[i] !== exp_q[i] || got_c_q[i] !== exp_c_q[i]) begin
            failures++;
            $display("FAIL len6_word%0d got=%h/%0d exp=%h/%0d",
                     i, got_w_q[i], got_c_q[i], exp_q[i], exp_c_q[i]);
         end
      end
      checks++;
      if (bus.o_img_data_counter !== 32'd6 || bus.o_done !== 1'b1) begin
         failures++;
         $display("FAIL len6_end cnt=%0d done=%b exp=6/1", bus.o_img_data_counter, bus.o_done);
      end
   endtask

   task automatic test_backpressure;
      do_start(32'd4);
      for (int i = 0; i < 4; i++) begin
         bus.i_pix_valid = 1'b1;
         bus.i_pix_data  = 8'h11 + 8'(i);
         @(negedge clk);
      end
      bus.i_pix_data   = 8'hEE;
      bus.i_word_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (bus.o_word_valid !== 1'b1 || bus.o_word_data !== 32'h14131211) begin
            failures++;
            $display("FAIL bp_hold%0d valid=%b word=%h exp=1/14131211",
                     k, bus.o_word_valid, bus.o_word_data);
         end
         checks++;
         if (bus.o_pix_ready !== 1'b0 || bus.o_img_data_counter !== 32'd0) begin
            failures++;
            $display("FAIL bp_ready%0d ready=%b cnt=%0d exp=0/0",
                     k, bus.o_pix_ready, bus.o_img_data_counter);
         end
         @(negedge clk);
      end
      bus.i_word_ready = 1'b1;
      @(negedge clk);
      bus.i_pix_valid = 1'b0;
      checks++;
      if (bus.o_done !== 1'b1 || bus.o_img_data_counter !== 32'd4 ||
          bus.o_word_valid !== 1'b0 || bus.o_word_data !== 32'd0) begin
         failures++;
         $display("FAIL bp_end done=%b cnt=%0d valid=%b word=%h exp=1/4/0/0",
                  bus.o_done, bus.o_img_data_counter, bus.o_word_valid, bus.o_word_data);
      end
   endtask

   task automatic test_len0;
      do_start(32'd0);
      checks++;
      if (bus.o_done !== 1'b1 || bus.o_busy !== 1'b0 ||
          bus.o_img_data_counter !== 32'd0 || bus.o_img_data_length !== 32'd0) begin
         failures++;
         $display("FAIL len0_done done=%b busy=%b cnt=%0d len=%0d exp=1/0/0/0",
                  bus.o_done, bus.o_busy, bus.o_img_data_counter, bus.o_img_data_length);
      end
      bus.i_pix_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (bus.o_word_valid !== 1'b0 || bus.o_pix_ready !== 1'b0) begin
            failures++;
            $display("FAIL len0_quiet%0d valid=%b ready=%b exp=0/0",
                     k, bus.o_word_valid, bus.o_pix_ready);
         end
      end
      bus.i_pix_valid = 1'b0;
   endtask

   task automatic test_reset_mid;
      int cyc;
      bit dn;
      do_start(32'd8);
      for (int i = 0; i < 3; i++) begin
         bus.i_pix_valid = 1'b1;
         bus.i_pix_data  = 8'h01 + 8'(i);
         @(negedge clk);
      end
      bus.i_pix_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.o_pix_ready, bus.o_word_valid, bus.o_busy, bus.o_done} !== 4'b0000 ||
          bus.o_word_data !== 32'd0 || bus.o_img_data_length !== 32'd0 ||
          bus.o_img_data_counter !== 32'd0) begin
         failures++;
         $display("FAIL rstmid_outputs flags=%b word=%h len=%0d cnt=%0d exp=all zero",
                  {bus.o_pix_ready, bus.o_word_valid, bus.o_busy, bus.o_done},
                  bus.o_word_data, bus.o_img_data_length, bus.o_img_data_counter);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (bus.o_word_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_idle%0d valid=%b busy=%b exp=0/0",
                     k, bus.o_word_valid, bus.o_busy);
         end
      end
      do_start(32'd1);
      stream_pixels(1, 8'h55, cyc, dn);
      checks++;
      if (got_w_q.size() != 1 || got_w_q[0] !== 32'h00000055 || got_c_q[0] !== 32'd0) begin
         failures++;
         $display("FAIL rstmid_word n=%0d word=%h exp=1 word 00000055",
                  got_w_q.size(), (got_w_q.size() > 0) ? got_w_q[0] : 32'hx);
      end
      checks++;
      if (!dn || bus.o_img_data_counter !== 32'd1) begin
         failures++;
         $display("FAIL rstmid_end done=%0d cnt=%0d exp=1/1", dn, bus.o_img_data_counter);
      end
   endtask

   task automatic test_start_ignored;
      int cyc;
      bit dn;
      do_start(32'd8);
      bus.i_pix_valid = 1'b1;
      bus.i_pix_data  = 8'h21;
      @(negedge clk);
      bus.i_pix_data   = 8'h22;
      bus.i_start      = 1'b1;
      bus.i_img_length = 32'd3;
      @(negedge clk);
      bus.i_start = 1'b0;
      checks++;
      if (bus.o_img_data_length !== 32'd8 || bus.o_busy !== 1'b1 ||
          bus.o_img_data_counter !== 32'd0) begin
         failures++;
         $display("FAIL ign_fill len=%0d busy=%b cnt=%0d exp=8/1/0",
                  bus.o_img_data_length, bus.o_busy, bus.o_img_data_counter);
      end
      bus.i_pix_data = 8'h23;
      @(negedge clk);
      bus.i_pix_data = 8'h24;
      @(negedge clk);
      checks++;
      if (bus.o_word_valid !== 1'b1 || bus.o_word_data !== 32'h24232221) begin
         failures++;
         $display("FAIL ign_word valid=%b word=%h exp=1/24232221",
                  bus.o_word_valid, bus.o_word_data);
      end
      bus.i_pix_valid  = 1'b0;
      bus.i_word_ready = 1'b0;
      bus.i_start      = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      checks++;
      if (bus.o_word_valid !== 1'b1 || bus.o_img_data_length !== 32'd8 ||
          bus.o_img_data_counter !== 32'd0) begin
         failures++;
         $display("FAIL ign_out valid=%b len=%0d cnt=%0d exp=1/8/0",
                  bus.o_word_valid, bus.o_img_data_length, bus.o_img_data_counter);
      end
      stream_pixels(4, 8'h25, cyc, dn);
      checks++;
      if (got_w_q.size() != 2 || got_w_q[1] !== 32'h28272625 || got_c_q[1] !== 32'd4) begin
         failures++;
         $display("FAIL ign_second n=%0d word=%h exp=2 words, 28272625 at cnt 4",
                  got_w_q.size(), (got_w_q.size() > 1) ? got_w_q[1] : 32'hx);
      end
      checks++;
      if (!dn || bus.o_img_data_counter !== 32'd8) begin
         failures++;
         $display("FAIL ign_end done=%0d cnt=%0d exp=1/8", dn, bus.o_img_data_counter);
      end
      do_start(32'd2);
      checks++;
      if (bus.o_img_data_length !== 32'd2 || bus.o_img_data_counter !== 32'd0 ||
          bus.o_pix_ready !== 1'b1) begin
         failures++;
         $display("FAIL restart_state len=%0d cnt=%0d ready=%b exp=2/0/1",
                  bus.o_img_data_length, bus.o_img_data_counter, bus.o_pix_ready);
      end
      stream_pixels(2, 8'h31, cyc, dn);
      checks++;
      if (got_w_q.size() != 1 || got_w_q[0] !== 32'h00003231 || !dn ||
          bus.o_img_data_counter !== 32'd2) begin
         failures++;
         $display("FAIL restart_word n=%0d word=%h done=%0d cnt=%0d exp=1/00003231/1/2",
                  got_w_q.size(), (got_w_q.size() > 0) ? got_w_q[0] : 32'hx,
                  dn, bus.o_img_data_counter);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      bus.i_start = 1'b0;
      bus.i_img_length = 32'd0;
      bus.i_pix_valid = 1'b0;
      bus.i_pix_data = 8'd0;
      bus.i_word_ready = 1'b1;
      test_reset();
      test_len8();
      test_partial();
      test_backpressure();
      test_len0();
      test_reset_mid();
      test_start_ignored();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
